logarithm: RTL

LOGARITHM -- requirements
Module: logarithm

---
 rtl/logarithm.sv | 122 ++++++++++++
 1 files changed

// File: rtl/logarithm.sv
// Sequential natural-log unit: a = prod(1 + 2^-k) by greedy shift-and-add,
// ln(a) accumulated from a 16-entry ROM of ln(1 + 2^-k) in U1.16.
module logarithm #(
    parameter int ITER = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  intpart,
    input  logic [15:0] fracpart,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic [16:0] y
);

    localparam int KW = $clog2(ITER + 1);
    localparam logic [KW-1:0] K_LAST = KW'(ITER);
    localparam logic [17:0]   ONE    = 18'h10000;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state, state_nxt;
    logic [17:0]   a, a_nxt;
    logic [17:0]   p, p_nxt;
    logic [16:0]   y_nxt;
    logic [KW-1:0] k, k_nxt;
    logic          err_nxt;
    logic [18:0]   t;
    logic          accept;
    logic [15:0]   lut_val;

    // round(ln(1 + 2^-k) * 65536)
    function automatic logic [15:0] lut_rom(input int idx);
        case (idx)
            1:       lut_rom = 16'd26573;
            2:       lut_rom = 16'd14624;
            3:       lut_rom = 16'd7719;
            4:       lut_rom = 16'd3973;
            5:       lut_rom = 16'd2017;
            6:       lut_rom = 16'd1016;
            7:       lut_rom = 16'd510;
            8:       lut_rom = 16'd256;
            9:       lut_rom = 16'd128;
            10:      lut_rom = 16'd64;
            11:      lut_rom = 16'd32;
            12:      lut_rom = 16'd16;
            13:      lut_rom = 16'd8;
            14:      lut_rom = 16'd4;
            15:      lut_rom = 16'd2;
            16:      lut_rom = 16'd1;
            default: lut_rom = 16'd0;
        endcase
    endfunction

    // t is one bit wider than p; p never exceeds a, so t[17:0] is lossless on accept
    assign t       = {1'b0, p} + ({1'b0, p} >> k);
    assign accept  = (t <= {1'b0, a});
    assign lut_val = lut_rom(int'(k));

    assign done = (state == DONE);
    assign busy = (state != IDLE);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        a_nxt     = a;
        p_nxt     = p;
        y_nxt     = y;
        k_nxt     = k;
        err_nxt   = err;
        case (state)
            IDLE: begin
                if (start) begin
                    a_nxt = {intpart, fracpart};
                    p_nxt = ONE;
                    y_nxt = '0;
                    k_nxt = KW'(1);
                    if (intpart == 2'd0) begin
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        err_nxt   = 1'b0;
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                if (accept) begin
                    p_nxt = t[17:0];
                    y_nxt = y + {1'b0, lut_val};
                end else if (k == K_LAST) begin
                    state_nxt = DONE;
                end else begin
                    k_nxt = k + KW'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            a     <= '0;
            p     <= ONE;
            y     <= '0;
            k     <= KW'(1);
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            a     <= a_nxt;
            p     <= p_nxt;
            y     <= y_nxt;
            k     <= k_nxt;
            err   <= err_nxt;
        end
    end

endmodule
